// File: rtl/logic_gate_pkg.sv
// Shared op codes, FSM state type and op-classification helpers for the
// registered bitwise gate unit.
package logic_gate_pkg;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_XOR   = 3'd2;
    localparam logic [2:0] OP_NAND  = 3'd3;
    localparam logic [2:0] OP_NOR   = 3'd4;
    localparam logic [2:0] OP_XNOR  = 3'd5;
    localparam logic [2:0] OP_RSVD6 = 3'd6;
    localparam logic [2:0] OP_RSVD7 = 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    function automatic logic is_inverting(input logic [2:0] op);
        return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
    endfunction

    function automatic logic is_reserved(input logic [2:0] op);
        return (op == OP_RSVD6) || (op == OP_RSVD7);
    endfunction

endpackage

// File: rtl/logic_gate_alu.sv
// Combinational bitwise gate: base function (AND/OR/XOR) of x and y plus its
// complement. Reserved op codes yield zero.
module logic_gate_alu
    import logic_gate_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [2:0]   op_i,
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    output logic [W-1:0] base_o,
    output logic [W-1:0] inv_o
);

    always_comb begin
        base_o = '0;
        case (op_i)
            OP_AND, OP_NAND: base_o = x_i & y_i;
            OP_OR,  OP_NOR:  base_o = x_i | y_i;
            OP_XOR, OP_XNOR: base_o = x_i ^ y_i;
            default:         base_o = '0;
        endcase
    end

    assign inv_o = ~base_o;

endmodule

// File: rtl/logic_gate_unit.sv
// Registered bitwise gate unit with valid/ready streaming and an optional
// accumulate mode that folds a multi-beat burst into a single result.
module logic_gate_unit
    import logic_gate_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_y,
    output logic             out_err,
    output logic [CNT_W-1:0] out_beats
);

    state_e             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [W-1:0]       acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [W-1:0]       out_y_q, out_y_d;
    logic               out_err_q, out_err_d;
    logic [CNT_W-1:0]   out_beats_q, out_beats_d;

    logic               accept;
    logic [2:0]         beat_op;
    logic [W-1:0]       beat_base, beat_inv;
    logic [W-1:0]       fold_base, fold_inv;
    logic [CNT_W-1:0]   cnt_sat;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Inside a burst the latched op governs every beat, not the live in_op.
    assign beat_op  = (state_q == ACCUM) ? op_q : in_op;
    assign cnt_sat  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    logic_gate_alu #(.W(W)) u_beat_alu (
        .op_i   (beat_op),
        .x_i    (in_a),
        .y_i    (in_b),
        .base_o (beat_base),
        .inv_o  (beat_inv)
    );

    logic_gate_alu #(.W(W)) u_fold_alu (
        .op_i   (op_q),
        .x_i    (acc_q),
        .y_i    (beat_base),
        .base_o (fold_base),
        .inv_o  (fold_inv)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q && !out_ready;
        out_y_d     = out_y_q;
        out_err_d   = out_err_q;
        out_beats_d = out_beats_q;

        if (accept) begin
            if (state_q == IDLE) begin
                if (!in_acc || in_last) begin
                    // Single beat, or a one-beat burst: emit directly.
                    out_valid_d = 1'b1;
                    out_err_d   = is_reserved(in_op);
                    out_y_d     = is_reserved(in_op)  ? '0 :
                                  is_inverting(in_op) ? beat_inv : beat_base;
                    out_beats_d = CNT_W'(1);
                    op_d        = in_acc ? in_op : op_q;
                    acc_d       = in_acc ? beat_base : acc_q;
                end else begin
                    state_d = ACCUM;
                    op_d    = in_op;
                    acc_d   = beat_base;
                    cnt_d   = CNT_W'(1);
                end
            end else begin
                acc_d = fold_base;
                cnt_d = cnt_sat;
                if (in_last) begin
                    out_valid_d = 1'b1;
                    out_err_d   = is_reserved(op_q);
                    out_y_d     = is_reserved(op_q)  ? '0 :
                                  is_inverting(op_q) ? fold_inv : fold_base;
                    out_beats_d = cnt_sat;
                    state_d     = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_AND;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_err_q   <= 1'b0;
            out_beats_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_err_q   <= out_err_d;
            out_beats_q <= out_beats_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_err   = out_err_q;
    assign out_beats = out_beats_q;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed self-checking bench for logic_gate_unit: default instance (W=8,
// CNT_W=8) plus a CNT_W=2 instance for beat-counter saturation.
module tb_logic_gate_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_acc, in_last, out_ready;
    logic [7:0] in_a, in_b;
    logic [2:0] in_op;
    logic       in_ready, out_valid, out_err;
    logic [7:0] out_y, out_beats;

    logic       s_in_valid, s_in_acc, s_in_last, s_out_ready;
    logic [7:0] s_in_a, s_in_b;
    logic [2:0] s_in_op;
    logic       s_in_ready, s_out_valid, s_out_err;
    logic [7:0] s_out_y;
    logic [1:0] s_out_beats;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    logic_gate_unit #(.W(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .in_acc(in_acc), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_err(out_err), .out_beats(out_beats)
    );

    logic_gate_unit #(.W(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .in_op(s_in_op),
        .in_acc(s_in_acc), .in_last(s_in_last),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_y(s_out_y), .out_err(s_out_err), .out_beats(s_out_beats)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one beat for exactly one cycle (dut is ready when called).
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic acc, input logic last);
        @(negedge clk);
        in_a = a; in_b = b; in_op = op; in_acc = acc; in_last = last; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic s_send(input logic [7:0] a, input logic [7:0] b, input logic last);
        @(negedge clk);
        s_in_a = a; s_in_b = b; s_in_op = 3'd1; s_in_acc = 1'b1; s_in_last = last;
        s_in_valid = 1'b1;
        @(posedge clk);
        #1 s_in_valid = 1'b0;
    endtask

    task automatic chk_result(input string tag, input logic [7:0] y, input logic [7:0] beats,
                              input logic err);
        @(negedge clk);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".y"},     32'(out_y),     32'(y));
        chk({tag, ".beats"}, 32'(out_beats), 32'(beats));
        chk({tag, ".err"},   32'(out_err),   32'(err));
    endtask

    initial begin
        logic [7:0] exp_sweep [6];
        exp_sweep = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33};

        rst = 1'b1; in_valid = 1'b0; in_acc = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_op = '0;
        s_in_valid = 1'b0; s_in_acc = 1'b0; s_in_last = 1'b0; s_out_ready = 1'b1;
        s_in_a = '0; s_in_b = '0; s_in_op = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("reset.valid", 32'(out_valid), 32'd0);
        chk("reset.y",     32'(out_y),     32'd0);
        chk("reset.err",   32'(out_err),   32'd0);
        chk("reset.beats", 32'(out_beats), 32'd0);
        chk("reset.ready", 32'(in_ready),  32'd1);

        // Single-beat sweep over ops 0-5.
        for (int i = 0; i < 6; i++) begin
            send(8'hF0, 8'h3C, 3'(i), 1'b0, 1'b0);
            chk_result($sformatf("sweep%0d", i), exp_sweep[i], 8'd1, 1'b0);
        end
        @(negedge clk);
        chk("sweep.drain", 32'(out_valid), 32'd0);

        // XNOR accumulate burst: xor-fold = 1F, inverted = E0.
        send(8'h01, 8'h02, 3'd5, 1'b1, 1'b0);
        @(negedge clk);
        chk("xnor.b1.valid", 32'(out_valid), 32'd0);
        send(8'h04, 8'h08, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("xnor.b2.valid", 32'(out_valid), 32'd0);
        send(8'h10, 8'h00, 3'd1, 1'b1, 1'b1);
        chk_result("xnor", 8'hE0, 8'd3, 1'b0);

        // Backpressure with two queued OR beats.
        @(negedge clk);
        out_ready = 1'b0;
        send(8'h0F, 8'h30, 3'd1, 1'b0, 1'b0);
        chk_result("bp.first", 8'h3F, 8'd1, 1'b0);
        chk("bp.in_ready", 32'(in_ready), 32'd0);
        in_a = 8'h01; in_b = 8'h80; in_op = 3'd1; in_acc = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        chk("bp.hold.y",     32'(out_y),     32'h3F);
        chk("bp.hold.valid", 32'(out_valid), 32'd1);
        chk("bp.hold.ready", 32'(in_ready),  32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk_result("bp.second", 8'h81, 8'd1, 1'b0);
        @(negedge clk);
        chk("bp.nodup", 32'(out_valid), 32'd0);

        // Reserved op then a valid AND.
        send(8'hFF, 8'hFF, 3'd7, 1'b0, 1'b0);
        chk_result("rsvd7", 8'h00, 8'd1, 1'b1);
        send(8'hAA, 8'h0F, 3'd0, 1'b0, 1'b0);
        chk_result("after_rsvd", 8'h0A, 8'd1, 1'b0);

        // Reset in the middle of an OR burst.
        send(8'h01, 8'h00, 3'd1, 1'b1, 1'b0);
        send(8'h02, 8'h00, 3'd1, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst.valid", 32'(out_valid), 32'd0);
        chk("midrst.beats", 32'(out_beats), 32'd0);
        send(8'h0F, 8'hFF, 3'd0, 1'b0, 1'b0);
        chk_result("midrst.and", 8'h0F, 8'd1, 1'b0);

        // Saturating beat count with CNT_W=2: OR of all operands = 7F.
        s_send(8'h01, 8'h02, 1'b0);
        s_send(8'h04, 8'h00, 1'b0);
        s_send(8'h08, 8'h00, 1'b0);
        s_send(8'h10, 8'h20, 1'b0);
        @(negedge clk);
        chk("sat.nodone", 32'(s_out_valid), 32'd0);
        s_send(8'h00, 8'h40, 1'b1);
        @(negedge clk);
        chk("sat.valid", 32'(s_out_valid), 32'd1);
        chk("sat.y",     32'(s_out_y),     32'h7F);
        chk("sat.beats", 32'(s_out_beats), 32'd3);
        chk("sat.err",   32'(s_out_err),   32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
